// File: rtl/au_serial_pkg.sv
// Shared encodings and helpers for the digit-serial add/subtract unit.
// Used by au_serial and au_digit.
package au_pkg;

   localparam logic AU_ADD = 1'b0;
   localparam logic AU_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } au_state_t;

   function automatic int au_cnt_w(input int d);
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/au_serial_digit.sv
// Combinational DIGIT-bit ripple adder slice; zero latency, no handshake.
// Also exposes the carry into its MSB so the caller can form signed overflow.
module au_digit
   import au_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] w_carry;

   always_comb begin
      w_carry    = '0;
      sum        = '0;
      w_carry[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]       = a[i] ^ b[i] ^ w_carry[i];
         w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
      end
   end

   assign cout     = w_carry[DIGIT];
   assign c_msb_in = w_carry[DIGIT-1];

endmodule

// File: rtl/au_serial.sv
// Digit-serial A+B / A-B with registered result and flags; D=WIDTH/DIGIT cycles from accept to out_valid.
// in_ready only in IDLE; DONE holds until out_ready. AU_SERIAL_SAT_EN enables saturating results.
module au_serial
   import au_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             c,
   output logic             v,
   output logic             z,
   output logic             n
);

   localparam int D  = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
   localparam int CW = au_cnt_w(D);
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_cfg
      $error("au_serial: WIDTH must be >=2 and a multiple of DIGIT, DIGIT must be >=1");
   end

   au_state_t              r_state;
   au_state_t              w_next;
   logic [WIDTH-1:0]       r_sa;
   logic [WIDTH-1:0]       r_sb;
   logic [WIDTH-1:0]       r_res;
   logic [WIDTH-1:0]       r_f;
   logic                   r_carry;
   logic                   r_c;
   logic                   r_v;
   logic                   r_z;
   logic                   r_n;
   logic [CW-1:0]          r_cnt;
   logic [DIGIT-1:0]       w_sum;
   logic                   w_cout;
   logic                   w_cmsb;
   logic [WIDTH+DIGIT-1:0] w_res_ext;
   logic [WIDTH-1:0]       w_res_nxt;
   logic [WIDTH-1:0]       w_f_fin;
   logic                   w_accept;
   logic                   w_last;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_state == RUN) && (r_cnt == LAST);

   au_digit #(.DIGIT(DIGIT)) u_digit (
      .a        (r_sa[DIGIT-1:0]),
      .b        (r_sb[DIGIT-1:0]),
      .cin      (r_carry),
      .sum      (w_sum),
      .cout     (w_cout),
      .c_msb_in (w_cmsb)
   );

   // Each new slice enters at the top, so after D slices the LSB slice sits at bit 0.
   assign w_res_ext = {w_sum, r_res};
   assign w_res_nxt = w_res_ext[WIDTH+DIGIT-1:DIGIT];

`ifdef AU_SERIAL_SAT_EN
   logic r_sign;

   // Overflow is only possible when the true result keeps A's sign.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_sign <= 1'b0;
      else if (w_accept) r_sign <= a[WIDTH-1];
   end

   always_comb begin
      w_f_fin = w_res_nxt;
      if (w_cout ^ w_cmsb)
         w_f_fin = r_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign w_f_fin = w_res_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_next = RUN;
         RUN:     if (w_last)    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_f     <= '0;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
      end else if (w_accept) begin
         r_sa    <= a;
         r_sb    <= (sel == AU_SUB) ? ~b : b;
         r_carry <= (sel == AU_SUB);
         r_cnt   <= '0;
         r_res   <= '0;
      end else if (r_state == RUN) begin
         r_sa    <= r_sa >> DIGIT;
         r_sb    <= r_sb >> DIGIT;
         r_res   <= w_res_nxt;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_f <= w_f_fin;
            r_c <= w_cout;
            r_v <= w_cout ^ w_cmsb;
            r_z <= (w_f_fin == '0);
            r_n <= w_f_fin[WIDTH-1];
         end
      end
   end

   assign f = r_f;
   assign c = r_c;
   assign v = r_v;
   assign z = r_z;
   assign n = r_n;

endmodule
